// File: rtl/arrhythmia_pkg.sv
// Shared types and Q4.11 sign-magnitude field widths for the arrhythmia host-side sequencer.
package arrhythmia_pkg;

  typedef enum logic [1:0] {COLLECT, LAUNCH, RUN, RESULT} seq_state_e;

  localparam int unsigned Q_WIDTH     = 16;
  localparam int unsigned Q_INT_BITS  = 4;
  localparam int unsigned Q_FRAC_BITS = 11;
  localparam int unsigned Q_MAG_BITS  = Q_INT_BITS + Q_FRAC_BITS;
  localparam int unsigned SM_SIGN_BIT = Q_WIDTH - 1;
  localparam int unsigned STAT_WIDTH  = 16;

endpackage

// File: rtl/sm_compare.sv
// Combinational sign-magnitude greater-than: gt = (a > b), with +0 ranked above -0.
module sm_compare
  import arrhythmia_pkg::*;
#(
  parameter int unsigned WIDTH = Q_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt
);

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-2:0] a_mag;
  logic [WIDTH-2:0] b_mag;

  always_comb begin
    a_neg = a[WIDTH-1];
    b_neg = b[WIDTH-1];
    a_mag = a[WIDTH-2:0];
    b_mag = b[WIDTH-2:0];
    gt    = 1'b0;
    if (a_neg != b_neg) begin
      // Signs differ: the positive operand wins even when both magnitudes are zero.
      gt = b_neg;
    end else if (a_neg) begin
      gt = (a_mag < b_mag);
    end else begin
      gt = (a_mag > b_mag);
    end
  end

endmodule

// File: rtl/arrhythmia_frame_sequencer.sv
// Packs NSAMP samples into the accelerator frame, launches inference, returns the class result.
// Optional accuracy statistics (s_label, stat_total, stat_correct) under ARR_SEQ_ACCURACY_EN.
module arrhythmia_frame_sequencer
  import arrhythmia_pkg::*;
#(
  parameter int unsigned BITSIZE    = 16,
  parameter int unsigned NSAMP      = 10,
  parameter int unsigned LAUNCH_CYC = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [BITSIZE-1:0]       s_data,
`ifdef ARR_SEQ_ACCURACY_EN
  input  logic                     s_label,
  output logic [STAT_WIDTH-1:0]    stat_total,
  output logic [STAT_WIDTH-1:0]    stat_correct,
`endif
  output logic                     acc_reset,
  output logic [BITSIZE*NSAMP-1:0] acc_x,
  input  logic [2*BITSIZE-1:0]     acc_y,
  input  logic                     acc_done,
  output logic                     r_valid,
  input  logic                     r_ready,
  output logic                     r_class,
  output logic [BITSIZE-1:0]       r_y1,
  output logic [BITSIZE-1:0]       r_y2,
  output logic                     r_timeout
);

  localparam int unsigned XW     = BITSIZE * NSAMP;
  localparam int unsigned IDX_W  = $clog2(XW);
  localparam int unsigned CNT_W  = $clog2(NSAMP + 1);
  localparam int unsigned LCNT_W = $clog2(LAUNCH_CYC + 1);
  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

  seq_state_e        state_q;
  logic [CNT_W-1:0]  count_q;
  logic [LCNT_W-1:0] lcnt_q;
  logic [TCNT_W-1:0] tcnt_q;
  logic [IDX_W-1:0]  slice_lsb;
  logic              y_gt;
`ifdef ARR_SEQ_ACCURACY_EN
  logic              label_q;
`endif

  // Sample k lands in the k-th slice counted from the MSB end of acc_x.
  assign slice_lsb = IDX_W'(BITSIZE * (NSAMP - 1 - 32'(count_q)));

  sm_compare #(
    .WIDTH(BITSIZE)
  ) u_cmp (
    .a  (acc_y[2*BITSIZE-1:BITSIZE]),
    .b  (acc_y[BITSIZE-1:0]),
    .gt (y_gt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= COLLECT;
      count_q      <= '0;
      lcnt_q       <= '0;
      tcnt_q       <= '0;
      acc_x        <= '0;
      acc_reset    <= 1'b1;
      s_ready      <= 1'b0;
      r_valid      <= 1'b0;
      r_class      <= 1'b0;
      r_y1         <= '0;
      r_y2         <= '0;
      r_timeout    <= 1'b0;
`ifdef ARR_SEQ_ACCURACY_EN
      label_q      <= 1'b0;
      stat_total   <= '0;
      stat_correct <= '0;
`endif
    end else begin
      unique case (state_q)
        COLLECT: begin
          acc_reset <= 1'b1;
          s_ready   <= 1'b1;
          if (s_valid && s_ready) begin
            acc_x[slice_lsb +: BITSIZE] <= s_data;
            count_q <= count_q + CNT_W'(1);
            if (count_q == CNT_W'(NSAMP - 1)) begin
              s_ready <= 1'b0;
              lcnt_q  <= '0;
              state_q <= LAUNCH;
`ifdef ARR_SEQ_ACCURACY_EN
              label_q <= s_label;
`endif
            end
          end
        end
        LAUNCH: begin
          if (lcnt_q == LCNT_W'(LAUNCH_CYC - 1)) begin
            acc_reset <= 1'b0;
            tcnt_q    <= '0;
            state_q   <= RUN;
          end else begin
            lcnt_q <= lcnt_q + LCNT_W'(1);
          end
        end
        RUN: begin
          tcnt_q <= tcnt_q + TCNT_W'(1);
          if (acc_done) begin
            r_y1      <= acc_y[2*BITSIZE-1:BITSIZE];
            r_y2      <= acc_y[BITSIZE-1:0];
            r_class   <= y_gt;
            r_timeout <= 1'b0;
            r_valid   <= 1'b1;
            acc_reset <= 1'b1;
            state_q   <= RESULT;
          end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
            r_y1      <= '0;
            r_y2      <= '0;
            r_class   <= 1'b0;
            r_timeout <= 1'b1;
            r_valid   <= 1'b1;
            acc_reset <= 1'b1;
            state_q   <= RESULT;
          end
        end
        RESULT: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            count_q <= '0;
            tcnt_q  <= '0;
            s_ready <= 1'b1;
            state_q <= COLLECT;
`ifdef ARR_SEQ_ACCURACY_EN
            if (!r_timeout) begin
              if (stat_total != '1) stat_total <= stat_total + STAT_WIDTH'(1);
              if ((r_class == label_q) && (stat_correct != '1)) begin
                stat_correct <= stat_correct + STAT_WIDTH'(1);
              end
            end
`endif
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_arrhythmia_frame_sequencer.sv
// Randomized bench for arrhythmia_frame_sequencer against an event-timestamp reference model.
module tb_arrhythmia_frame_sequencer;

  localparam int BITSIZE    = 16;
  localparam int NSAMP      = 10;
  localparam int LAUNCH_CYC = 2;
  localparam int TIMEOUT    = 20;
  localparam int XW         = BITSIZE * NSAMP;
  localparam int N_FR       = 24;
  localparam int RST_FR     = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [BITSIZE-1:0] s_data = '0;
  logic acc_reset;
  logic [XW-1:0] acc_x;
  logic [2*BITSIZE-1:0] acc_y = '0;
  logic acc_done = 1'b0;
  logic r_valid;
  logic r_ready = 1'b0;
  logic r_class;
  logic [BITSIZE-1:0] r_y1, r_y2;
  logic r_timeout;
`ifdef ARR_SEQ_ACCURACY_EN
  logic s_label = 1'b0;
  logic [15:0] stat_total, stat_correct;
  bit cfg_label [N_FR+2];
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [BITSIZE-1:0] samp [N_FR+1][NSAMP];
  logic [2*BITSIZE-1:0] cfg_y [N_FR+2];
  int cfg_lat [N_FR+2];

  arrhythmia_frame_sequencer #(
    .BITSIZE(BITSIZE), .NSAMP(NSAMP), .LAUNCH_CYC(LAUNCH_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
`ifdef ARR_SEQ_ACCURACY_EN
    .s_label(s_label), .stat_total(stat_total), .stat_correct(stat_correct),
`endif
    .acc_reset(acc_reset), .acc_x(acc_x), .acc_y(acc_y), .acc_done(acc_done),
    .r_valid(r_valid), .r_ready(r_ready), .r_class(r_class),
    .r_y1(r_y1), .r_y2(r_y2), .r_timeout(r_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [XW-1:0] act, input logic [XW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Sign-magnitude values as signed integers; +0 beats -0 as the only tie-break.
  function automatic bit sm_gt(input logic [15:0] a, input logic [15:0] b);
    int va, vb;
    va = a[15] ? -int'(a[14:0]) : int'(a[14:0]);
    vb = b[15] ? -int'(b[14:0]) : int'(b[14:0]);
    if (va != vb) return va > vb;
    return !a[15] && b[15];
  endfunction

  // Reference model: outputs derived from accepted-sample count and edge timestamps.
  int m_cyc = 0, n_acc = 0, t_last = 0, elapsed;
  bit m_pend = 0;
  logic e_s_ready = 0, e_acc_reset = 1, e_r_valid = 0, e_r_class = 0, e_r_timeout = 0;
  logic [XW-1:0] e_acc_x = '0;
  logic [BITSIZE-1:0] e_r_y1 = '0, e_r_y2 = '0;
`ifdef ARR_SEQ_ACCURACY_EN
  int e_total = 0, e_correct = 0;
  logic m_label = 0;
`endif

  task automatic model_reset();
    n_acc = 0; m_pend = 0;
    e_s_ready = 0; e_acc_reset = 1; e_r_valid = 0; e_r_class = 0; e_r_timeout = 0;
    e_acc_x = '0; e_r_y1 = '0; e_r_y2 = '0;
`ifdef ARR_SEQ_ACCURACY_EN
    e_total = 0; e_correct = 0;
`endif
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      m_cyc++;
      if (m_pend) begin
        if (r_ready) begin
          m_pend = 0; n_acc = 0; e_r_valid = 0; e_s_ready = 1;
`ifdef ARR_SEQ_ACCURACY_EN
          if (!e_r_timeout) begin
            if (e_total < 65535) e_total++;
            if (e_r_class == m_label && e_correct < 65535) e_correct++;
          end
`endif
        end
      end else if (n_acc < NSAMP) begin
        if (s_valid && e_s_ready) begin
          e_acc_x[BITSIZE*(NSAMP-n_acc)-1 -: BITSIZE] = s_data;
          n_acc++;
          if (n_acc == NSAMP) t_last = m_cyc;
`ifdef ARR_SEQ_ACCURACY_EN
          if (n_acc == NSAMP) m_label = s_label;
`endif
        end
        e_s_ready = (n_acc < NSAMP);
      end else begin
        elapsed = m_cyc - t_last;
        if (elapsed == LAUNCH_CYC) begin
          e_acc_reset = 0;
        end else if (elapsed > LAUNCH_CYC) begin
          if (acc_done) begin
            e_r_y1 = acc_y[31:16]; e_r_y2 = acc_y[15:0];
            e_r_class = sm_gt(acc_y[31:16], acc_y[15:0]); e_r_timeout = 0; m_pend = 1;
          end else if (elapsed - LAUNCH_CYC == TIMEOUT) begin
            e_r_y1 = '0; e_r_y2 = '0; e_r_class = 0; e_r_timeout = 1; m_pend = 1;
          end
          if (m_pend) begin e_r_valid = 1; e_acc_reset = 1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("s_ready", s_ready, e_s_ready);
    chk("acc_reset", acc_reset, e_acc_reset);
    chk("acc_x", acc_x, e_acc_x);
    chk("r_valid", r_valid, e_r_valid);
    if (e_r_valid) begin
      chk("r_class", r_class, e_r_class);
      chk("r_y1", r_y1, e_r_y1);
      chk("r_y2", r_y2, e_r_y2);
      chk("r_timeout", r_timeout, e_r_timeout);
    end
`ifdef ARR_SEQ_ACCURACY_EN
    chk("stat_total", stat_total, e_total[15:0]);
    chk("stat_correct", stat_correct, e_correct[15:0]);
`endif
  end

  // Accelerator stand-in: done after cfg_lat RUN cycles (0 = never), noise on done while held in reset.
  int fidx = 0, run_cnt = 0;
  bit was_run = 0;
  always @(posedge clk) begin
    #1;
    if (acc_reset) begin
      if (was_run) fidx++;
      was_run = 0; run_cnt = 0;
      acc_done = ($urandom_range(0, 3) == 0);
    end else begin
      was_run = 1; run_cnt++;
      acc_done = (cfg_lat[fidx] != 0) && (run_cnt >= cfg_lat[fidx]);
    end
    acc_y = cfg_y[fidx];
  end

  task automatic send_frame(input int f);
    bit got;
    int w;
    for (int k = 0; k < NSAMP; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_valid = 0; s_data = BITSIZE'($urandom);
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      s_valid = 1; s_data = samp[f][k];
`ifdef ARR_SEQ_ACCURACY_EN
      s_label = cfg_label[f];
`endif
      got = 0; w = 0;
      while (!got && w < 200) begin
        @(negedge clk); got = s_ready;
        @(posedge clk); #1; w++;
      end
      if (!got) chk("sample_accept_wait", 1'b0, 1'b1);
    end
    // Often keep s_valid high with the next frame's first sample across launch/run/result.
    if ($urandom_range(0, 1) == 1) s_data = samp[f+1][0];
    else s_valid = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n, m, exp_run, hold;
    logic [BITSIZE-1:0] f0 [NSAMP];
    f0 = '{16'h0471, 16'h03B4, 16'h0290, 16'h8120, 16'h8355,
           16'h0012, 16'h07FF, 16'h8001, 16'h0100, 16'h0A5A};
    for (int f = 0; f <= N_FR; f++)
      for (int k = 0; k < NSAMP; k++) samp[f][k] = (f == 0) ? f0[k] : BITSIZE'($urandom);
    for (int f = 0; f < N_FR + 2; f++) begin
      cfg_y[f] = $urandom;
      case ($urandom_range(0, 2))
        0: cfg_y[f][15:0] = cfg_y[f][31:16];
        1: cfg_y[f][15:0] = cfg_y[f][31:16] ^ 16'h8000;
        default: ;
      endcase
      case ($urandom_range(0, 9))
        0: cfg_lat[f] = 0;
        1: cfg_lat[f] = TIMEOUT;
        2: cfg_lat[f] = TIMEOUT + 1;
        3: cfg_lat[f] = 1;
        default: cfg_lat[f] = $urandom_range(1, 25);
      endcase
`ifdef ARR_SEQ_ACCURACY_EN
      cfg_label[f] = 1'($urandom_range(0, 1));
`endif
    end
    cfg_y[0] = {16'h0800, 16'h8400}; cfg_lat[0] = 5;
    cfg_y[1] = {16'h8200, 16'h8100}; cfg_lat[1] = 3;
    cfg_y[2] = {16'h0000, 16'h8000}; cfg_lat[2] = 7;
    cfg_y[3] = {16'h0400, 16'h0400}; cfg_lat[3] = 1;
    cfg_lat[4] = 0;
    cfg_y[5] = {16'h8001, 16'h0002}; cfg_lat[5] = 10;
    cfg_lat[RST_FR] = 0;
`ifdef ARR_SEQ_ACCURACY_EN
    cfg_label[0] = 1; cfg_label[1] = 1; cfg_label[2] = 0; cfg_label[3] = 0;
`endif

    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    #1 chk("s_ready_before_first_edge", s_ready, 1'b0);
    @(posedge clk); #1;
    chk("s_ready_after_first_edge", s_ready, 1'b1);

    for (int f = 0; f < N_FR; f++) begin
      send_frame(f);
      n = 0;
      while (acc_reset && n < 10) begin @(posedge clk); #1; n++; end
      chk("launch_cycles", n, LAUNCH_CYC);
      if (f == 0) begin
        chk("acc_x_first_slice", acc_x[XW-1 -: BITSIZE], 16'h0471);
        chk("acc_x_last_slice", acc_x[BITSIZE-1:0], 16'h0A5A);
      end
      if (f == RST_FR) begin
        repeat (3) @(posedge clk);
        #1 reset_n = 0;
        #1;
        chk("rst_acc_reset", acc_reset, 1'b1);
        chk("rst_r_valid", r_valid, 1'b0);
        chk("rst_acc_x", acc_x, '0);
        chk("rst_s_ready", s_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        continue;
      end
      m = 0;
      while (!r_valid && m < 100) begin @(posedge clk); #1; m++; end
      exp_run = (cfg_lat[f] == 0 || cfg_lat[f] > TIMEOUT) ? TIMEOUT : cfg_lat[f];
      chk("run_cycles", m, exp_run);
      case (f)
        0: begin
          chk("f0_class", r_class, 1'b1);
          chk("f0_y1", r_y1, 16'h0800);
          chk("f0_timeout", r_timeout, 1'b0);
        end
        1: chk("neg_neg_class", r_class, 1'b0);
        2: chk("pos0_neg0_class", r_class, 1'b1);
        3: chk("equal_class", r_class, 1'b0);
        4: begin
          chk("to_flag", r_timeout, 1'b1);
          chk("to_class", r_class, 1'b0);
          chk("to_y", {r_y1, r_y2}, '0);
        end
        default: ;
      endcase
      hold = (f == 5) ? 5 : $urandom_range(0, 3);
      repeat (hold) @(posedge clk);
      if (f == 5) begin
        #1;
        chk("hold_r_valid", r_valid, 1'b1);
        chk("hold_s_ready", s_ready, 1'b0);
      end
      @(negedge clk); r_ready = 1;
      @(posedge clk); #1 r_ready = 0;
      if (f == 5) chk("s_ready_after_handshake", s_ready, 1'b1);
`ifdef ARR_SEQ_ACCURACY_EN
      if (f == 3) begin
        chk("stat_total_lit", stat_total, 16'd4);
        chk("stat_correct_lit", stat_correct, 16'd2);
      end
`endif
    end

    s_valid = 0;
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arrhythmia_frame_sequencer.md
Name: arrhythmia_frame_sequencer

Overview:
- Host-side companion to the arrhythmia accelerator (top_arrhythmia).
- Accepts ECG samples one at a time over a valid/ready stream and packs NSAMP samples into the accelerator's flat x bus.
- Pulses the accelerator's reset to launch inference, waits for done_flag_out, captures y1/y2 and decides the class by sign-magnitude compare (y1 > y2 gives class 1).
- Returns the result over a valid/ready stream, replacing bench-side sequencing with synthesizable control.

Parameters:
- BITSIZE, 16, sample/output width; sign-magnitude Q4.11 (bit 15 sign, 14:11 integer, 10:0 fraction).
- NSAMP, 10, samples per inference frame.
- LAUNCH_CYC, 2, cycles acc_reset is held high after the frame completes.
- TIMEOUT, 255, max RUN cycles waiting for acc_done.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample ready.
- s_data  in  BITSIZE  sample.
- acc_reset  out  1  active-high reset to accelerator.
- acc_x  out  BITSIZE*NSAMP  packed frame to accelerator x.
- acc_y  in  2*BITSIZE  accelerator y, {y1,y2}.
- acc_done  in  1  accelerator done_flag_out.
- r_valid  out  1  result valid.
- r_ready  in  1  result ready.
- r_class  out  1  1 when y1 > y2.
- r_y1  out  BITSIZE  captured y1.
- r_y2  out  BITSIZE  captured y2.
- r_timeout  out  1  result produced by timeout.

Behaviour:
- Reset: clk and reset_n as above; reset is asynchronous, active-low. While reset_n=0: state COLLECT, sample count 0, acc_x=0, acc_reset=1, s_ready=0, r_valid=0, r_class=0, r_y1=r_y2=0, r_timeout=0, timeout counter 0.
- Reset release: s_ready goes 1 on the first clk edge after reset_n rises, and not before.
- All outputs are registered.

State machine:
- COLLECT
  - s_ready=1, acc_reset=1.
  - On each s_valid&&s_ready, store the sample in slice k, where slice k = acc_x[BITSIZE*(NSAMP-k)-1 -: BITSIZE]. The first sample goes to the MSB slice.
  - Count increments on each accepted sample.
  - The NSAMP-th accept goes to LAUNCH, and s_ready drops on that same edge.
- LAUNCH
  - s_ready=0, acc_reset=1 for exactly LAUNCH_CYC cycles, then RUN.
  - acc_done is ignored here.
- RUN
  - acc_reset=0; acc_x is held stable.
  - Timeout counter increments every cycle.
  - If acc_done=1 is sampled: capture acc_y[2*BITSIZE-1:BITSIZE] to r_y1 and acc_y[BITSIZE-1:0] to r_y2, compute r_class, set r_timeout=0, go to RESULT.
  - Else, when the counter reaches TIMEOUT: r_timeout=1, r_class=0, r_y1=r_y2=0, go to RESULT.
  - acc_done and timeout in the same cycle: acc_done wins.
- RESULT
  - r_valid=1; all r_* held stable until r_valid&&r_ready.
  - On handshake: r_valid=0, count=0, timeout counter=0, go to COLLECT (acc_reset stays 1).
  - s_ready=0 throughout; no overlap of collection and result.

Latency:
- Last sample accepted at edge t: acc_reset falls at edge t+LAUNCH_CYC.
- acc_done first sampled high at edge u: r_valid=1 from edge u.

Class compare, sign-magnitude, no two's-complement conversion:
- Signs differ: positive is greater, so +0 (0x0000) vs -0 (0x8000) gives r_class=1.
- Both positive: magnitude greater gives 1.
- Both negative: magnitude smaller gives 1.
- Equal: r_class=0.

Other boundary rules:
- s_data is ignored when s_ready=0.
- s_valid may stay high across frames.
- Reset mid-operation aborts any state immediately; a partial frame is discarded.

Optional Feature:
- Macro ARR_SEQ_ACCURACY_EN.
- Defined:
  - Adds input s_label (1).
  - Adds outputs stat_total (16) and stat_correct (16).
  - s_label is sampled with the NSAMP-th sample.
  - On each non-timeout result handshake: stat_total increments, and stat_correct increments when r_class==label.
  - Both counters saturate at 0xFFFF and reset to 0.
- Undefined: these ports and counters are absent; core behaviour is identical.

Decomposition:
- Package arrhythmia_pkg: sequencer state enum (COLLECT, LAUNCH, RUN, RESULT), Q4.11 sign-magnitude field widths, SM_SIGN_BIT constant.
- Sub-module sm_compare (combinational sign-magnitude a>b), reusable by other result comparators.

Test Plan:
1. Reset, then send 10 samples starting 0x0471, 0x03B4, … with s_valid held high -> s_ready low after the 10th; acc_x[159:144]=0x0471, acc_x[15:0]=10th sample; acc_reset falls 2 cycles later.
2. Model asserts acc_done with y1=0x0800, y2=0x8400 -> r_valid on that edge, r_class=1, r_y1=0x0800, r_timeout=0.
3. y1=0x8200, y2=0x8100 -> r_class=0; y1=0x0000, y2=0x8000 -> r_class=1; y1=y2=0x0400 -> r_class=0.
4. TIMEOUT=20, acc_done never asserted -> r_valid after 20 RUN cycles, r_timeout=1, r_class=0, r_y1=r_y2=0.
5. Hold r_ready low 5 cycles -> r_* stable, s_ready=0; on handshake, s_ready=1 the next cycle and a new frame is accepted.
6. Assert reset_n=0 mid-RUN -> acc_reset=1, r_valid=0, acc_x=0 immediately; the next full frame is processed correctly. With ARR_SEQ_ACCURACY_EN: 3 frames with labels 1, 0, 0 and classes 1, 1, 0 -> stat_total=3, stat_correct=2.
